// File: rtl/ram_arbiter_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for two requesters; the pointer only matters when both request.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic grant
);

  always_comb begin
    if (req0 && req1) grant = pointer;
    else              grant = req1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (CPU / loader) arbiter onto a single-port RAM with a tristate data bus.
// Define RAM_ARB_RR_EN for round-robin on collisions; otherwise port 0 has fixed priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] address_RAM,
  output logic          csRAM,
  output logic          weRAM,
  inout  wire  [DW-1:0] data
);

  state_t        state;
  logic          lat_we;
  logic          lat_port;
  logic [DW-1:0] lat_wdata;
  logic          pointer;
  logic          grant;
  logic          in_access;

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)                              pointer <= 1'b0;
    else if (state == IDLE && (req0 || req1)) pointer <= ~pointer;
  end
`else
  assign pointer = 1'b0;
`endif

  ram_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .pointer (pointer),
    .grant   (grant)
  );

  // Gated by reset so an in-flight write is cut off in the cycle reset is seen.
  assign in_access = (state == ACCESS) && !reset;
  assign csRAM     = in_access;
  assign weRAM     = in_access && lat_we;
  assign data      = weRAM ? lat_wdata : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      address_RAM <= '0;
      rdata       <= '0;
      lat_we      <= 1'b0;
      lat_port    <= 1'b0;
      lat_wdata   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state       <= ACCESS;
            lat_port    <= grant;
            lat_we      <= grant ? we1 : we0;
            address_RAM <= grant ? addr1 : addr0;
            lat_wdata   <= grant ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (!lat_we) rdata <= data;
          ack0  <= !lat_port;
          ack1  <= lat_port;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural RAM on the shared bus plus a
// bench-side reference memory that predicts read data when requests are issued.
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 4;
  localparam logic [DW-1:0] IDLE_PAT = 4'b0101;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, csRAM, weRAM;
  logic [DW-1:0] rdata;
  logic [AW-1:0] address_RAM;
  wire  [DW-1:0] data;

  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata       (rdata),
    .address_RAM (address_RAM),
    .csRAM       (csRAM),
    .weRAM       (weRAM),
    .data        (data)
  );

  always #5 clk = ~clk;

  // RAM drives reads; a known pattern sits on the bus whenever nobody should drive it.
  assign data = (csRAM && weRAM) ? 'z : (csRAM ? ram[address_RAM] : IDLE_PAT);

  always @(posedge clk) if (csRAM && weRAM) ram[address_RAM] <= data;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack0 || ack1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack got ack0=%b ack1=%b want no ack", ack0, ack1);
      end else begin
        e = sb.pop_front();
        if ((ack0 && ack1) || ack1 !== e.port) begin
          bad++;
          $display("FAIL sb_ack_port got ack0=%b ack1=%b want port %0d", ack0, ack1, e.port);
        end
        if (!e.we) begin
          total++;
          if (rdata !== e.rd) begin
            bad++;
            $display("FAIL sb_rdata got %b want %b", rdata, e.rd);
          end
        end
      end
    end
  end

  task automatic raise(input logic port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  task automatic post(input logic port, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.rd   = ref_mem[a];
    sb.push_back(e);
    if (we) ref_mem[a] = wd;
  endtask

  task automatic wait_ack(input logic port);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_timeout got no ack%0d want ack within 12 cycles", port);
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ack0, ack1, csRAM, weRAM} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ctrl got ack0/ack1/cs/we=%b want 0000", {ack0, ack1, csRAM, weRAM});
    end
    total++;
    if (address_RAM !== 12'h000) begin
      bad++; $display("FAIL rst_addr got %h want 000", address_RAM);
    end
    total++;
    if (rdata !== 4'b0000) begin
      bad++; $display("FAIL rst_rdata got %b want 0000", rdata);
    end
    total++;
    if (data !== IDLE_PAT) begin
      bad++; $display("FAIL rst_bus got %b want %b (undriven by dut)", data, IDLE_PAT);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    raise(1'b0, 1'b1, 12'h001, 4'b1011);
    post(1'b0, 1'b1, 12'h001, 4'b1011);
    @(negedge clk);
    total++;
    if (csRAM !== 1'b0 || data !== IDLE_PAT) begin
      bad++; $display("FAIL wr_idle got cs=%b bus=%b want 0 %b", csRAM, data, IDLE_PAT);
    end
    @(negedge clk);
    total++;
    if ({csRAM, weRAM, ack0} !== 3'b110 || address_RAM !== 12'h001) begin
      bad++;
      $display("FAIL wr_access got cs/we/ack0=%b addr=%h want 110 001", {csRAM, weRAM, ack0}, address_RAM);
    end
    total++;
    if (data !== 4'b1011) begin
      bad++; $display("FAIL wr_bus got %b want 1011", data);
    end
    @(negedge clk);
    total++;
    if ({ack0, csRAM, weRAM} !== 3'b100 || data !== IDLE_PAT) begin
      bad++;
      $display("FAIL wr_done got ack0/cs/we=%b bus=%b want 100 %b", {ack0, csRAM, weRAM}, data, IDLE_PAT);
    end
    req0 = 1'b0;

    @(posedge clk); #1;
    raise(1'b0, 1'b0, 12'h001, 4'b0000);
    post(1'b0, 1'b0, 12'h001, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({csRAM, weRAM} !== 2'b10 || data !== 4'b1011) begin
      bad++; $display("FAIL rd_access got cs/we=%b bus=%b want 10 1011", {csRAM, weRAM}, data);
    end
    @(negedge clk);
    total++;
    if (ack0 !== 1'b1 || rdata !== 4'b1011) begin
      bad++; $display("FAIL rd_done got ack0=%b rdata=%b want 1 1011", ack0, rdata);
    end
    req0 = 1'b0;
  endtask

  task automatic test_boundary();
    @(posedge clk); #1;
    raise(1'b1, 1'b1, 12'hFFF, 4'b1111);
    post(1'b1, 1'b1, 12'hFFF, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (address_RAM !== 12'hFFF || weRAM !== 1'b1 || data !== 4'b1111) begin
      bad++; $display("FAIL bnd_write got addr=%h we=%b bus=%b want fff 1 1111", address_RAM, weRAM, data);
    end
    wait_ack(1'b1);
    total++;
    if (rdata !== 4'b1011) begin
      bad++; $display("FAIL wr_keeps_rdata got %b want 1011", rdata);
    end
    @(posedge clk); #1;
    raise(1'b0, 1'b0, 12'hFFF, 4'b0000);
    post(1'b0, 1'b0, 12'hFFF, 4'b0000);
    wait_ack(1'b0);
    total++;
    if (rdata !== 4'b1111) begin
      bad++; $display("FAIL bnd_read got %b want 1111", rdata);
    end
    total++;
    if (address_RAM !== 12'hFFF) begin
      bad++; $display("FAIL addr_hold got %h want fff", address_RAM);
    end
  endtask

  task automatic test_drop_req();
    int extra = 0;
    @(posedge clk); #1;
    raise(1'b1, 1'b0, 12'h001, 4'b0000);
    post(1'b1, 1'b0, 12'h001, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    total++;
    if (ack1 !== 1'b1) begin
      bad++; $display("FAIL drop_ack got ack1=%b want 1", ack1);
    end
    repeat (5) begin
      @(negedge clk);
      if (csRAM || ack0 || ack1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL drop_no_repeat got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_write();
    int stray = 0;
    @(posedge clk); #1;
    raise(1'b0, 1'b1, 12'h055, 4'b0110);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (weRAM !== 1'b1) begin
      bad++; $display("FAIL rmw_pre got we=%b want 1", weRAM);
    end
    reset = 1'b1;
    req0  = 1'b0;
    #1;
    total++;
    if ({csRAM, weRAM} !== 2'b00) begin
      bad++; $display("FAIL rmw_cut got cs/we=%b want 00", {csRAM, weRAM});
    end
    @(negedge clk);
    total++;
    if ({ack0, ack1, csRAM, weRAM} !== 4'b0000 || rdata !== 4'b0000 || address_RAM !== 12'h000) begin
      bad++;
      $display("FAIL rmw_after got ack0/ack1/cs/we=%b rdata=%b addr=%h want 0000 0000 000",
               {ack0, ack1, csRAM, weRAM}, rdata, address_RAM);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1 || csRAM) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL rmw_no_ack got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_collision();
    int         n = 0;
    logic [3:0] order = '0;
    logic [3:0] want;
    @(posedge clk); #1;
    raise(1'b0, 1'b0, 12'h001, 4'b0000);
    raise(1'b1, 1'b0, 12'hFFF, 4'b0000);
`ifdef RAM_ARB_RR_EN
    want = 4'b1010;
    post(1'b0, 1'b0, 12'h001, 4'b0000);
    post(1'b1, 1'b0, 12'hFFF, 4'b0000);
    post(1'b0, 1'b0, 12'h001, 4'b0000);
    post(1'b1, 1'b0, 12'hFFF, 4'b0000);
`else
    want = 4'b0000;
    repeat (4) post(1'b0, 1'b0, 12'h001, 4'b0000);
    post(1'b1, 1'b0, 12'hFFF, 4'b0000);
`endif
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        order[n] = ack1;
        n++;
      end
    end
    req0 = 1'b0;
`ifdef RAM_ARB_RR_EN
    req1 = 1'b0;
`endif
    total++;
    if (n !== 4 || order !== want) begin
      bad++; $display("FAIL coll_order got n=%0d order=%b want 4 %b", n, order, want);
    end
`ifndef RAM_ARB_RR_EN
    wait_ack(1'b1);
`endif
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got no finish want finish before 100us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    test_reset();
    test_write_read();
    test_boundary();
    test_drop_req();
    test_reset_mid_write();
    test_collision();

    repeat (4) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, RAM address width.
REQ-002 SHALL have parameter DW, default 4, RAM data width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have ports req0/req1  input  1  access request, port 0 (CPU) / port 1 (loader).
REQ-007 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1  input  AW  access address.
REQ-009 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-010 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  DW  read data, valid while ack0 or ack1 is high.
REQ-012 SHALL have port address_RAM  output  AW  RAM address.
REQ-013 SHALL have port csRAM  output  1  RAM chip select.
REQ-014 SHALL have port weRAM  output  1  RAM write enable.
REQ-015 SHALL have port data  inout  DW  RAM bidirectional data bus.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: if any req high, SHALL select a winner, latch its we/addr/wdata and go to ACCESS; else stay in IDLE.
REQ-018 ACCESS: SHALL assert csRAM, drive address_RAM from the latch and weRAM = latched we for exactly one cycle, then go to DONE.
REQ-019 SHALL drive data with latched wdata only when state = ACCESS and weRAM = 1; otherwise data SHALL be all-Z.
REQ-020 On a read, SHALL register data into rdata at the clock edge leaving ACCESS.
REQ-021 DONE: SHALL pulse the winner's ack for one cycle, then return to IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N gives ACCESS during cycle N+1 and ack during cycle N+2; at most one access per 3 cycles.
REQ-023 Requesters SHALL hold req/we/addr/wdata until ack; dropping req after grant SHALL NOT abort the access, and ack SHALL still be issued.
REQ-024 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-025 Outside ACCESS, csRAM = 0, weRAM = 0, and address_RAM SHALL hold its last value.
REQ-026 rdata SHALL hold its value until the next read completes; write accesses SHALL leave rdata unchanged.
REQ-027 Address 12'hFFF SHALL be passed through unchanged; the block performs no address arithmetic.

Reset
REQ-028 On reset, state = IDLE, ack0 = ack1 = 0, csRAM = 0, weRAM = 0, address_RAM = 0, rdata = 0, data = Z, and priority pointer = port 0.
REQ-029 Reset asserted in ACCESS or DONE SHALL abandon the access with no ack, and the RAM write SHALL stop in the same cycle.

Configuration
REQ-030 With RAM_ARB_RR_EN defined, the winner for simultaneous requests SHALL be the port named by the pointer; the pointer SHALL toggle to the other port on every grant.
REQ-031 Without RAM_ARB_RR_EN, port 0 SHALL always win simultaneous requests, and no pointer register SHALL exist.
REQ-032 With only one req high, that port SHALL win in both builds.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, ACCESS, DONE) and AW/DW default constants.
REQ-034 The winner-select logic SHALL be a sub-module ram_arb_pick (inputs req0, req1, pointer; output grant index); the FSM and bus drive SHALL stay in ram_arbiter.

Verification
REQ-035 Write then read: req0 writes addr 12'h001 with 4'b1011, then reads 12'h001 -> weRAM high for 1 cycle, ack0 at N+2, and read rdata = 4'b1011.
REQ-036 Collision: req0 and req1 high in the same cycle, repeated 4 times -> with RAM_ARB_RR_EN, grants alternate 0,1,0,1; without it, all 4 grants go to port 0 before any port 1 grant.
REQ-037 Bus tristate: during IDLE, DONE and read ACCESS cycles, data = 4'bzzzz; during write ACCESS, data = wdata.
REQ-038 Reset mid-write: assert reset in ACCESS -> the next cycle has weRAM = 0, csRAM = 0 and no ack.
REQ-039 Drop req: req1 deasserted during ACCESS -> ack1 still pulses once, and no second access follows.
REQ-040 Boundary address: port 1 writes 4'b1111 to 12'hFFF, then port 0 reads 12'hFFF -> rdata = 4'b1111.
